fir_scheduler: RTL and testbench
================================

# fir_scheduler

Round-robin scheduler that shares one multi-channel FIR engine between NCH sample sources. Each channel gets a one-deep input holding register with a valid/ready handshake. The scheduler issues one sample at a time to the engine, tagged with its channel number, and waits for the engine's done pulse. It then returns the filtered result, tagged with the same channel, on a valid/ready output port. It sits between the per-channel sample front ends and the FIR engine, and it owns all engine sequencing.

## Interface
- NCH, 4, number of requesting channels (2..16)
- DW, 16, signed sample/result width
- TIMEOUT, 32, max cycles in BUSY before abort (≥ 20; engine nominal latency is 18)
- ck  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- in_valid  input  NCH  per-channel sample valid
- in_data  input  NCH×DW  per-channel signed samples, channel i at [i*DW +: DW]
- in_ready  output  NCH  per-channel holding register empty
- eng_start  output  1  one-cycle pulse, engine begins a sample
- eng_chan  output  $clog2(NCH)  channel context for engine
- eng_sample  output  DW  sample to engine
- eng_done  input  1  one-cycle pulse, eng_result valid this cycle
- eng_result  input  DW  signed filtered result
- out_valid  output  1  result available
- out_data  output  DW  result
- out_chan  output  $clog2(NCH)  channel of result
- out_ready  input  1  downstream accepts
- err_timeout  output  1  one-cycle pulse, engine failed to finish
- err_chan  output  $clog2(NCH)  channel of aborted sample

## Operation
- Holding registers: buf_valid[i] is set when in_valid[i] && in_ready[i], and that cycle loads buf_data[i]. in_ready[i] = !buf_valid[i], driven purely from the register. Clearing a buffer and reloading it cannot happen in the same cycle: one bubble per sample per channel.
- Arbiter: rr_ptr holds the last granted channel. The search starts at rr_ptr+1 mod NCH and wraps; the first channel with buf_valid wins. rr_ptr updates to the winner only on issue.
- FSM states: IDLE, ISSUE, BUSY, OUTPUT.
  - IDLE: if any buf_valid, latch the winner into cur_chan and go to ISSUE. Otherwise stay.
  - ISSUE: eng_start=1. Drive eng_chan=cur_chan and eng_sample=buf_data[cur_chan]. Clear buf_valid[cur_chan]. Clear the timeout counter. Go to BUSY.
  - BUSY: eng_chan and eng_sample stay stable (held registers). The timeout counter increments each cycle.
    - On eng_done, capture eng_result into out_data and cur_chan into out_chan, then go to OUTPUT.
    - If the counter reaches TIMEOUT-1 with no done, pulse err_timeout with err_chan=cur_chan. The sample is discarded. Go to IDLE.
    - If eng_done and the timeout fall in the same cycle, eng_done wins.
  - OUTPUT: out_valid=1. When out_ready, go to IDLE. No new issue while out_valid is high.
- eng_done outside BUSY is ignored, and no state changes.
- Arithmetic: no arithmetic on data. Results pass through unmodified. The timeout counter is $clog2(TIMEOUT) bits and saturates (never wraps).
- Input buffers keep accepting in every FSM state.

## Timing
- Reset (rst=0 at an edge) does the following, including mid-operation:
  - State goes to IDLE, all buf_valid=0, rr_ptr=NCH-1 (so channel 0 wins first), counter=0.
  - Outputs: in_ready all 1, eng_start=0, eng_chan=0, eng_sample=0, out_valid=0, out_data=0, out_chan=0, err_timeout=0, err_chan=0.
  - An in-flight engine result is dropped. A late eng_done after reset is ignored.
- Latency, idle system: in_valid accepted at edge T0, IDLE→ISSUE at T1, eng_start high in the cycle after T1, eng_done at Tn, out_valid high from Tn+1. Total = engine latency + 3 cycles.
- eng_start is high for exactly one cycle per issued sample.
- out_valid/out_data/out_chan are registered and stay stable until the out_ready handshake completes.
- Throughput: one sample per (engine latency + 3 + output stall) cycles, shared across all channels.

## Test plan
- Reset then single sample: ch2 sends 16'sd1000. Expect in_ready[2] to drop for one sample, one eng_start with eng_chan=2 and eng_sample=1000. Model responds with done plus result 16'sd500 after 18 cycles. Expect out_valid with out_data=500 and out_chan=2.
- Fairness: all 4 channels hold samples continuously. Expect issue order 0,1,2,3,0,1,… and no channel issued twice before the others.
- Backpressure: out_ready=0 for 10 cycles after the first result. Expect out_valid and out_data held stable and no eng_start until the handshake completes. Input buffers still fill.
- Timeout: model never asserts eng_done with TIMEOUT=32. Expect err_timeout pulsed once, 32 cycles after issue, with err_chan equal to the issued channel, and no out_valid. The next pending channel is then issued.
- Boundaries:
  - eng_done and timeout in the same cycle: expect the result delivered and no err_timeout.
  - Spurious eng_done in IDLE: expect it ignored.
- Mid-operation reset: assert rst=0 during BUSY. Expect all outputs at their reset values the next cycle. A late eng_done afterwards produces no out_valid.

Source files
------------

// File: rtl/fir_scheduler.sv
//==============================================================================
// Module   : fir_scheduler
// Purpose  : Round-robin scheduler that shares one multi-channel FIR engine
//            between NCH sample sources. Each channel owns a one-deep holding
//            register. One sample at a time is issued to the engine, tagged
//            with its channel, and the result is returned tagged with the
//            same channel on a valid/ready output port. An engine that does
//            not finish within TIMEOUT cycles is abandoned and reported.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   ck           in   1        clock, rising edge
//   rst          in   1        synchronous reset, active low
//   in_valid     in   NCH      per-channel sample valid
//   in_data      in   NCH*DW   per-channel samples, channel i at [i*DW +: DW]
//   in_ready     out  NCH      per-channel holding register empty
//   eng_start    out  1        one-cycle pulse, engine begins a sample
//   eng_chan     out  CW       channel context for the engine
//   eng_sample   out  DW       sample presented to the engine
//   eng_done     in   1        one-cycle pulse, eng_result valid
//   eng_result   in   DW       filtered result from the engine
//   out_valid    out  1        result available
//   out_data     out  DW       result
//   out_chan     out  CW       channel of the result
//   out_ready    in   1        downstream accepts the result
//   err_timeout  out  1        one-cycle pulse, engine failed to finish
//   err_chan     out  CW       channel of the aborted sample
//==============================================================================
`default_nettype none

module fir_scheduler #(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH*DW-1:0]       in_data,
  output logic [NCH-1:0]          in_ready,
  output logic                    eng_start,
  output logic [$clog2(NCH)-1:0]  eng_chan,
  output logic signed [DW-1:0]    eng_sample,
  input  logic                    eng_done,
  input  logic signed [DW-1:0]    eng_result,
  output logic                    out_valid,
  output logic signed [DW-1:0]    out_data,
  output logic [$clog2(NCH)-1:0]  out_chan,
  input  logic                    out_ready,
  output logic                    err_timeout,
  output logic [$clog2(NCH)-1:0]  err_chan
);

  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CHAN = CW'(NCH - 1);
  localparam logic [TW-1:0] CNT_LIMIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [NCH-1:0]  buf_valid;
  logic [DW-1:0]   buf_data [NCH];
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   cur_chan;
  logic [CW-1:0]   winner;
  logic            any_valid;
  logic [TW-1:0]   cnt;
  logic            cnt_at_limit;

  // (base + off) mod NCH, computed in int so non-power-of-two NCH wraps correctly.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NCH;
    return CW'(sum);
  endfunction

  //----------------------------------------------------------------------------
  // Holding registers. A buffer is only cleared in ISSUE for cur_chan, and at
  // that time it is full, so in_ready is low and a load cannot collide.
  //----------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (!rst) begin
      buf_valid <= '0;
      for (int i = 0; i < NCH; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= in_data[i*DW +: DW];
        end else if (state == ISSUE && cur_chan == CW'(i)) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign in_ready = ~buf_valid;

  //----------------------------------------------------------------------------
  // Round-robin search starting one past the last granted channel. Scanning
  // from the farthest offset down lets the nearest pending channel win.
  //----------------------------------------------------------------------------
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NCH; k >= 1; k--) begin
      if (buf_valid[wrap_add(rr_ptr, k)]) begin
        any_valid = 1'b1;
        winner    = wrap_add(rr_ptr, k);
      end
    end
  end

  assign cnt_at_limit = (cnt == CNT_LIMIT);

  //----------------------------------------------------------------------------
  // FSM state register
  //----------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // FSM next state and pulse outputs. A done arriving in the same cycle as the
  // timeout limit is honoured as a normal completion.
  //----------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    eng_start   = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (eng_done) begin
          state_nxt = OUTPUT;
        end else if (cnt_at_limit) begin
          err_timeout = 1'b1;
          state_nxt   = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign err_chan = err_timeout ? cur_chan : '0;

  //----------------------------------------------------------------------------
  // Datapath registers. The engine context is loaded on the IDLE->ISSUE edge
  // so it is already valid while eng_start is high and holds through BUSY.
  //----------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (!rst) begin
      rr_ptr     <= LAST_CHAN;
      cur_chan   <= '0;
      eng_chan   <= '0;
      eng_sample <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
    end else begin
      out_valid <= (state_nxt == OUTPUT);
      case (state)
        IDLE: begin
          if (any_valid) begin
            cur_chan   <= winner;
            eng_chan   <= winner;
            eng_sample <= buf_data[winner];
          end
        end
        ISSUE: begin
          rr_ptr <= cur_chan;
          cnt    <= '0;
        end
        BUSY: begin
          // Saturating: the counter never wraps even if the limit is held.
          if (!cnt_at_limit) begin
            cnt <= cnt + TW'(1);
          end
          if (eng_done) begin
            out_data <= eng_result;
            out_chan <= cur_chan;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_scheduler.sv
//==============================================================================
// Module   : tb_fir_scheduler
// Purpose  : Directed self-checking bench for fir_scheduler (NCH=4, DW=16,
//            TIMEOUT=32). The engine is modelled inline by driving eng_done
//            and eng_result a chosen number of cycles after eng_start.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fir_scheduler;

  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 32;

  logic                   ck;
  logic                   rst;
  logic [NCH-1:0]         in_valid;
  logic [NCH*DW-1:0]      in_data;
  logic [NCH-1:0]         in_ready;
  logic                   eng_start;
  logic [1:0]             eng_chan;
  logic signed [DW-1:0]   eng_sample;
  logic                   eng_done;
  logic signed [DW-1:0]   eng_result;
  logic                   out_valid;
  logic signed [DW-1:0]   out_data;
  logic [1:0]             out_chan;
  logic                   out_ready;
  logic                   err_timeout;
  logic [1:0]             err_chan;

  int errors = 0;
  int checks = 0;

  fir_scheduler #(
    .NCH     (NCH),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ck          (ck),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .eng_start   (eng_start),
    .eng_chan    (eng_chan),
    .eng_sample  (eng_sample),
    .eng_done    (eng_done),
    .eng_result  (eng_result),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_ready   (out_ready),
    .err_timeout (err_timeout),
    .err_chan    (err_chan)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Wait for an issue, check its tag and sample, then answer with done in
  // BUSY cycle 'lat' (counter value lat-1) and check the returned result.
  task automatic serve(input logic [1:0] exp_ch, input logic [15:0] exp_s,
                       input logic signed [15:0] res, input int lat);
    int n;
    n = 0;
    while (eng_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("issue_start", eng_start, 1);
    check("issue_chan", eng_chan, exp_ch);
    check("issue_sample", eng_sample, exp_s);
    tick();
    check("start_pulse", eng_start, 0);
    repeat (lat - 1) tick();
    eng_done   = 1'b1;
    eng_result = res;
    #1;
    check("no_err_on_done", err_timeout, 0);
    tick();
    eng_done   = 1'b0;
    check("res_valid", out_valid, 1);
    check("res_data", out_data, res);
    check("res_chan", out_chan, exp_ch);
  endtask

  initial begin
    int pulses;
    int at;
    int ov;
    logic [1:0] errch;

    rst        = 1'b0;
    in_valid   = '0;
    in_data    = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    out_ready  = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_chan", eng_chan, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err_timeout, 0);

    // ---------------- single sample on ch2 ----------------
    rst = 1'b1;
    in_data[2*DW +: DW] = 16'sd1000;
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    check("s1_in_ready_low", in_ready, 4'b1011);
    check("s1_no_start_yet", eng_start, 0);
    tick();
    check("s1_start", eng_start, 1);
    check("s1_chan", eng_chan, 2);
    check("s1_sample", eng_sample, 1000);
    tick();
    check("s1_start_pulse", eng_start, 0);
    check("s1_in_ready_back", in_ready, 4'hF);
    repeat (16) tick();
    check("s1_chan_stable", eng_chan, 2);
    check("s1_sample_stable", eng_sample, 1000);
    check("s1_no_out_yet", out_valid, 0);
    tick();
    eng_done   = 1'b1;
    eng_result = 16'sd500;
    tick();
    eng_done = 1'b0;
    check("s1_out_valid", out_valid, 1);
    check("s1_out_data", out_data, 500);
    check("s1_out_chan", out_chan, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("s1_out_drop", out_valid, 0);

    // ---------------- spurious done in IDLE ----------------
    eng_done   = 1'b1;
    eng_result = 16'sd321;
    tick();
    eng_done = 1'b0;
    check("spur_no_out", out_valid, 0);
    tick();
    check("spur_no_out2", out_valid, 0);
    check("spur_data_kept", out_data, 500);
    check("spur_no_start", eng_start, 0);

    // ---------------- fairness ----------------
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) in_data[i*DW +: DW] = 16'(100 + i);
    in_valid = 4'hF;
    serve(2'd0, 16'd100, 16'sd200, 4);
    serve(2'd1, 16'd101, 16'sd201, 4);
    serve(2'd2, 16'd102, 16'sd202, 4);
    serve(2'd3, 16'd103, 16'sd203, 4);
    serve(2'd0, 16'd100, 16'sd204, 4);
    serve(2'd1, 16'd101, 16'sd205, 4);
    in_valid = '0;

    // ---------------- backpressure, then mid-operation reset ----------------
    do_reset();
    out_ready = 1'b0;
    in_data = '0;
    in_data[0*DW +: DW] = 16'sd7;
    in_data[1*DW +: DW] = 16'sd8;
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    serve(2'd0, 16'd7, 16'sd70, 5);
    in_valid = 4'b0010;
    tick();
    in_valid = '0;
    check("bp_buf_fills", in_ready, 4'b1101);
    for (int c = 0; c < 9; c++) begin
      check("bp_valid_held", out_valid, 1);
      check("bp_data_held", out_data, 70);
      check("bp_no_start", eng_start, 0);
      tick();
    end
    check("bp_chan_held", out_chan, 0);
    out_ready = 1'b1;
    tick();
    check("bp_handshake", out_valid, 0);
    tick();
    check("bp_next_start", eng_start, 1);
    check("bp_next_chan", eng_chan, 1);
    check("bp_next_sample", eng_sample, 8);
    tick();
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_in_ready", in_ready, 4'hF);
    check("mr_eng_start", eng_start, 0);
    check("mr_eng_chan", eng_chan, 0);
    check("mr_eng_sample", eng_sample, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_out_data", out_data, 0);
    check("mr_out_chan", out_chan, 0);
    check("mr_err", err_timeout, 0);
    eng_done   = 1'b1;
    eng_result = 16'sd77;
    tick();
    eng_done = 1'b0;
    check("late_done_no_out", out_valid, 0);
    tick();
    check("late_done_no_out2", out_valid, 0);
    check("late_done_data", out_data, 0);

    // ---------------- timeout, then done/timeout coincidence ----------------
    do_reset();
    out_ready = 1'b1;
    in_data = '0;
    in_data[1*DW +: DW] = 16'sd55;
    in_data[3*DW +: DW] = 16'sd66;
    in_valid = 4'b1010;
    tick();
    in_valid = '0;
    begin
      int n;
      n = 0;
      while (eng_start !== 1'b1 && n < 60) begin
        tick();
        n++;
      end
    end
    check("to_start", eng_start, 1);
    check("to_chan", eng_chan, 1);
    check("to_sample", eng_sample, 55);
    pulses = 0;
    at     = 0;
    ov     = 0;
    errch  = '0;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (err_timeout === 1'b1) begin
        pulses++;
        at    = c;
        errch = err_chan;
      end
      if (out_valid === 1'b1) ov++;
    end
    check("to_pulse_count", pulses, 1);
    check("to_pulse_cycle", at, 32);
    check("to_err_chan", errch, 1);
    check("to_no_out", ov, 0);
    serve(2'd3, 16'd66, -16'sd2000, 32);
    tick();
    check("coinc_no_err_after", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
